// File: rtl/serial_deframer_pkg.sv
// Shared types and default constants for the serial sync-word deframer.
package serial_deframer_pkg;

  localparam int DATA_W = 8;
  localparam int SYNC_W = 4;
  localparam logic [3:0] SYNC_PAT = 4'b1011;

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    PARITY
  } state_t;

endpackage

// File: rtl/serial_deframer_sync.sv
// Sync-word hunter: bit history, fill counter and match detect.
// History and fill are held clear whenever hunting is disabled.
module serial_deframer_sync #(
  parameter int SYNC_W = serial_deframer_pkg::SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT =
    serial_deframer_pkg::SYNC_PAT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_match
);
  import serial_deframer_pkg::*;

  localparam int FW = $clog2(SYNC_W);

  logic [SYNC_W-2:0] r_hist;
  logic [FW-1:0]     r_fill;
  logic [SYNC_W-1:0] w_cat;
  logic              w_full;

  assign w_cat   = {r_hist, i_d};
  assign w_full  = (r_fill == FW'(SYNC_W - 1));
  assign o_match = i_en && w_full && (w_cat == SYNC_PAT);

  always_ff @(posedge clk) begin
    if (rst || !i_en || o_match) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      r_hist <= w_cat[SYNC_W-2:0];
      if (!w_full)
        r_fill <= r_fill + 1'b1;
    end
  end

endmodule

// File: rtl/serial_deframer.sv
// Serial deframer: hunts a sync word, then collects DATA_W payload bits.
// Define SERIAL_DEFRAMER_PARITY_EN to add a trailing even-parity bit.
module serial_deframer #(
  parameter int DATA_W = serial_deframer_pkg::DATA_W,
  parameter int SYNC_W = serial_deframer_pkg::SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT =
    serial_deframer_pkg::SYNC_PAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              par_err
);
  import serial_deframer_pkg::*;

  localparam int BW = $clog2(DATA_W);

  state_t            r_state;
  logic [BW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_busy;
  logic [DATA_W-1:0] w_next;
  logic              w_match;
  logic              w_last;

  assign w_next = {r_shift[DATA_W-2:0], d};
  assign w_last = (r_cnt == BW'(DATA_W - 1));

  serial_deframer_sync #(
    .SYNC_W  (SYNC_W),
    .SYNC_PAT(SYNC_PAT)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == HUNT),
    .i_d    (d),
    .o_match(w_match)
  );

`ifdef SERIAL_DEFRAMER_PARITY_EN
  logic r_perr;
  assign par_err = r_perr;
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_match) begin
            r_state <= DATA;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        DATA: begin
          r_shift <= w_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
            r_state <= PARITY;
`else
            r_state <= HUNT;
            r_busy  <= 1'b0;
            r_data  <= w_next;
            r_valid <= 1'b1;
`endif
          end
        end
`ifdef SERIAL_DEFRAMER_PARITY_EN
        PARITY: begin
          r_state <= HUNT;
          r_busy  <= 1'b0;
          r_data  <= r_shift;
          r_valid <= 1'b1;
          r_perr  <= d ^ (^r_shift);
        end
`endif
        default: begin
          r_state <= HUNT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_serial_deframer.sv
// Directed, table-driven bench for serial_deframer (default params).
module tb_serial_deframer;

`ifdef SERIAL_DEFRAMER_PARITY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d   = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       par_err;

  int n_pass  = 0;
  int n_total = 0;

  int         edge_idx;
  int         n_pulse;
  int         busy_cnt;
  int         dbl;
  bit         prev_v;
  logic [7:0] pdata[$];
  int         pedge[$];
  logic       last_perr;

  serial_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic [31:0] pre;
    int         pre_len;
    bit         has_pay;
    logic [7:0] pay;
    bit         flip;
    int         exp_n;
    int         exp_edge;
    bit         exp_perr;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s act=%0d req=%0d", nm, act, exp);
  endtask

  task automatic clr_mon();
    edge_idx = 0; n_pulse = 0; busy_cnt = 0;
    dbl = 0; prev_v = 0; last_perr = 0;
    pdata.delete(); pedge.delete();
  endtask

  task automatic step(input bit b, input bit r);
    d = b; rst = r;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (data_valid) begin
      n_pulse++;
      pdata.push_back(data_out);
      pedge.push_back(edge_idx);
      last_perr = par_err;
      if (prev_v) dbl++;
    end
    prev_v = data_valid;
    if (busy) busy_cnt++;
    edge_idx++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1);
    clr_mon();
  endtask

  task automatic send_frame(input logic [7:0] p, input bit flip);
    step(1'b1, 0); step(1'b0, 0);
    step(1'b1, 0); step(1'b1, 0);
    for (int i = 7; i >= 0; i--) step(p[i], 0);
    if (PEN == 1) step((^p) ^ flip, 0);
  endtask

  initial begin
    vt[0] = '{"ca", 32'hB, 4, 1, 8'hCA, 0, 1, 11 + PEN, 0};
    vt[1] = '{"slip", 32'h2B, 6, 1, 8'h5A, 0, 1, 13 + PEN, 0};
    vt[2] = '{"b0_nest", 32'hB, 4, 1, 8'hB0, 0, 1, 11 + PEN, 0};
    vt[3] = '{"zero_pay", 32'hB, 4, 1, 8'h00, 0, 1, 11 + PEN, 0};
    vt[4] = '{"nosync", 32'h932, 12, 0, 8'h00, 0, 0, 0, 0};
    vt[5] = '{"badpar", 32'hB, 4, 1, 8'hCA, 1, 1, 11 + PEN,
              bit'(PEN)};

    do_reset();
    chk("rst_data", int'(data_out), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_perr", int'(par_err), 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = vt[v].pre_len - 1; i >= 0; i--)
        step(vt[v].pre[i], 0);
      if (vt[v].has_pay) begin
        for (int i = 7; i >= 0; i--) step(vt[v].pay[i], 0);
        if (PEN == 1) step((^vt[v].pay) ^ vt[v].flip, 0);
      end
      for (int i = 0; i < 6; i++) step(1'b0, 0);
      chk({vt[v].name, "_npulse"}, n_pulse, vt[v].exp_n);
      chk({vt[v].name, "_busy"}, busy_cnt,
          vt[v].exp_n > 0 ? 8 + PEN : 0);
      if (n_pulse > 0 && vt[v].exp_n > 0) begin
        chk({vt[v].name, "_data"}, int'(pdata[0]),
            int'(vt[v].pay));
        chk({vt[v].name, "_edge"}, pedge[0], vt[v].exp_edge);
        chk({vt[v].name, "_perr"}, int'(last_perr),
            int'(vt[v].exp_perr));
      end
    end

    do_reset();
    step(1, 0); step(0, 0); step(1, 0); step(1, 0);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(1, 1);
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_busy", int'(busy), 0);
    send_frame(8'h3C, 0);
    for (int i = 0; i < 4; i++) step(0, 0);
    chk("midrst_npulse", n_pulse, 1);
    if (n_pulse > 0) chk("midrst_val", int'(pdata[0]), 8'h3C);

    do_reset();
    send_frame(8'hCA, 0);
    send_frame(8'h35, 0);
    for (int i = 0; i < 4; i++) step(0, 0);
    chk("b2b_npulse", n_pulse, 2);
    chk("b2b_dbl", dbl, 0);
    if (n_pulse == 2) begin
      chk("b2b_v0", int'(pdata[0]), 8'hCA);
      chk("b2b_v1", int'(pdata[1]), 8'h35);
      chk("b2b_gap", pedge[1] - pedge[0], 12 + PEN);
    end

    do_reset();
    step(1, 0); step(0, 0); step(1, 0);
    step(1, 1);
    chk("rstprio_busy", int'(busy), 0);
    for (int i = 0; i < 10; i++) step(0, 0);
    chk("rstprio_npulse", n_pulse, 0);
    chk("rstprio_bcnt", busy_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
